branch_seq_ctrl: RTL and testbench

//  Multi-cycle next-PC sequencer. Owns the PC register, accepts one instruction at a time,

---
 rtl/branch_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_branch_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq_ctrl.sv
// Multi-cycle next-PC sequencer: IDLE -> {CMP | UPD} -> UPD -> IDLE, owns the PC register.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module branch_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ins_valid,
   output logic        ins_ready,
   input  logic [31:0] ins,
   input  logic [31:0] rs_data,
   input  logic        branch,
   output logic        compare,
   output logic [31:0] cmp_ins,
   output logic [31:0] pc,
   output logic        pc_we,
   output logic [31:0] pc_next,
   output logic        flush,
   output logic        link_we,
   output logic [4:0]  link_addr,
`ifdef BRANCH_STATS_EN
   input  logic        stats_clr,
   output logic [15:0] br_total,
   output logic [15:0] br_taken,
`endif
   output logic [31:0] link_data
);

   typedef enum logic [1:0] {IDLE, CMP, UPD} state_t;

   state_t      state, state_nx;
   logic        accept;
   logic [31:0] ins_q, pc4_q, rs_q;
   logic [31:0] tgt_idle, tgt_cmp;
   logic        compare_r, pc_we_r, flush_r, link_we_r;
   logic [4:0]  link_addr_r;
   logic [31:0] pc_r, pc_next_r;

   function automatic logic is_cond_branch(input logic [31:0] i);
      logic [5:0] op;
      op = i[31:26];
      return (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000111) ||
             (op == 6'b000110) ||
             ((op == 6'b000001) && ((i[20:16] == 5'd0) || (i[20:16] == 5'd1)));
   endfunction

   function automatic logic is_jal(input logic [31:0] i);
      return i[31:26] == 6'b000011;
   endfunction

   function automatic logic is_jalr(input logic [31:0] i);
      return (i[31:26] == 6'b000000) && (i[5:0] == 6'b001001);
   endfunction

   // Target for any instruction; taken is only meaningful for conditional branches.
   function automatic logic [31:0] calc_target(input logic [31:0] i, input logic [31:0] pc4,
                                               input logic [31:0] rs, input logic taken);
      logic signed [31:0] off;
      logic [31:0]        tgt;
      off = {{14{i[15]}}, i[15:0], 2'b00};
      tgt = pc4;
      if ((i[31:26] == 6'b000010) || (i[31:26] == 6'b000011))
         tgt = {pc4[31:28], i[25:0], 2'b00};
      else if ((i[31:26] == 6'b000000) && ((i[5:0] == 6'b001000) || (i[5:0] == 6'b001001)))
         tgt = rs;
      else if (is_cond_branch(i) && taken)
         tgt = pc4 + $unsigned(off);
      return tgt;
   endfunction

   assign ins_ready = (state == IDLE);
   assign accept    = ins_valid & ins_ready;
   assign tgt_idle  = calc_target(ins, pc_r + 32'd4, rs_data, 1'b0);
   assign tgt_cmp   = calc_target(ins_q, pc4_q, rs_q, branch);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = is_cond_branch(ins) ? CMP : UPD;
         CMP:     state_nx = UPD;
         UPD:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand held for the JR/JALR target; never observed before it is written.
   always_ff @(posedge clk) begin
      if (accept) rs_q <= rs_data;
   end

   // All control pulses are registered one state ahead so they are glitch-free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         compare_r   <= 1'b0;
         pc_we_r     <= 1'b0;
         flush_r     <= 1'b0;
         link_we_r   <= 1'b0;
         link_addr_r <= 5'd0;
         pc_next_r   <= 32'd0;
         ins_q       <= 32'd0;
         pc4_q       <= 32'd0;
      end else begin
         compare_r <= 1'b0;
         pc_we_r   <= 1'b0;
         flush_r   <= 1'b0;
         link_we_r <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               ins_q       <= ins;
               pc4_q       <= pc_r + 32'd4;
               link_addr_r <= is_jal(ins) ? 5'd31 : (is_jalr(ins) ? ins[15:11] : 5'd0);
               if (is_cond_branch(ins)) begin
                  compare_r <= 1'b1;
               end else begin
                  pc_we_r   <= 1'b1;
                  pc_next_r <= tgt_idle;
                  flush_r   <= (tgt_idle != pc_r + 32'd4);
                  link_we_r <= is_jal(ins) | is_jalr(ins);
               end
            end
            CMP: begin
               pc_we_r   <= 1'b1;
               pc_next_r <= tgt_cmp;
               flush_r   <= (tgt_cmp != pc4_q);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)       pc_r <= RESET_PC;
      else if (pc_we_r) pc_r <= pc_next_r;
   end

`ifdef BRANCH_STATS_EN
   logic [15:0] br_total_r, br_taken_r;

   always_ff @(posedge clk) begin
      if (!rst_n || stats_clr) begin
         br_total_r <= 16'd0;
         br_taken_r <= 16'd0;
      end else if (state == CMP) begin
         if (br_total_r != 16'hFFFF)            br_total_r <= br_total_r + 16'd1;
         if (branch && (br_taken_r != 16'hFFFF)) br_taken_r <= br_taken_r + 16'd1;
      end
   end

   assign br_total = br_total_r;
   assign br_taken = br_taken_r;
`endif

   assign compare   = compare_r;
   assign cmp_ins   = ins_q;
   assign pc        = pc_r;
   assign pc_we     = pc_we_r;
   assign pc_next   = pc_next_r;
   assign flush     = flush_r;
   assign link_we   = link_we_r;
   assign link_addr = link_addr_r;
   assign link_data = pc4_q;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Scoreboard bench for branch_seq_ctrl: expected commits are queued at issue and
// compared when pc_we appears.
module tb_branch_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ins_valid = 1'b0;
   logic        ins_ready;
   logic [31:0] ins = 32'd0;
   logic [31:0] rs_data = 32'd0;
   logic        branch = 1'b0;
   logic        compare;
   logic [31:0] cmp_ins;
   logic [31:0] pc;
   logic        pc_we;
   logic [31:0] pc_next;
   logic        flush;
   logic        link_we;
   logic [4:0]  link_addr;
   logic [31:0] link_data;
`ifdef BRANCH_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] br_total, br_taken;
`endif

   branch_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ins_valid (ins_valid),
      .ins_ready (ins_ready),
      .ins       (ins),
      .rs_data   (rs_data),
      .branch    (branch),
      .compare   (compare),
      .cmp_ins   (cmp_ins),
      .pc        (pc),
      .pc_we     (pc_we),
      .pc_next   (pc_next),
      .flush     (flush),
      .link_we   (link_we),
      .link_addr (link_addr),
`ifdef BRANCH_STATS_EN
      .stats_clr (stats_clr),
      .br_total  (br_total),
      .br_taken  (br_taken),
`endif
      .link_data (link_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] npc;
      logic        fl;
      logic        lw;
      logic [4:0]  la;
      logic [31:0] ld;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] model_pc = 32'h0000_3000;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic model_isbr(input logic [31:0] i);
      case (i[31:26])
         6'd4, 6'd5, 6'd6, 6'd7: return 1'b1;
         6'd1:                   return (i[20:16] < 5'd2);
         default:                return 1'b0;
      endcase
   endfunction

   function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                  input logic [31:0] rs, input logic br);
      exp_t        e;
      logic [31:0] p4;
      logic [5:0]  op;
      logic [5:0]  fn;
      op = i[31:26];
      fn = i[5:0];
      p4 = p + 32'd4;
      e.npc = p4;
      if (op == 6'd2 || op == 6'd3)              e.npc = {p4[31:28], i[25:0], 2'b00};
      else if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) e.npc = rs;
      else if (model_isbr(i) && br)              e.npc = p4 + {{14{i[15]}}, i[15:0], 2'b00};
      e.fl  = (e.npc != p4);
      e.lw  = (op == 6'd3) || (op == 6'd0 && fn == 6'd9);
      e.la  = (op == 6'd3) ? 5'd31 : i[15:11];
      e.ld  = p4;
      e.lat = model_isbr(i) ? 2 : 1;
      return e;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ins_valid = 1'b0; branch = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      model_pc = 32'h0000_3000;
      @(negedge clk);
      check_val("rst_pc", pc, 32'h0000_3000);
      check_val("rst_pc_we", pc_we, 0);
      check_val("rst_ready", ins_ready, 1);
      check_val("rst_compare", compare, 0);
      check_val("rst_flush", flush, 0);
      check_val("rst_link_we", link_we, 0);
   endtask

   // Issues one instruction; hold keeps ins_valid high through CMP/UPD.
   task automatic issue(input string tag, input logic [31:0] i, input logic [31:0] rs,
                        input logic br, input logic hold);
      exp_t e;
      int   cmp_cnt;
      bit   done;
      @(negedge clk);
      check_val({tag, "_ready"}, ins_ready, 1);
      ins = i; rs_data = rs; ins_valid = 1'b1;
      sb.push_back(model(i, model_pc, rs, br));
      cmp_cnt = 0;
      done = 0;
      for (int n = 1; n <= 4 && !done; n++) begin
         @(negedge clk);
         if (!hold) ins_valid = 1'b0;
         branch = 1'b0;
         if (compare) begin
            cmp_cnt++;
            check_val({tag, "_cmp_ins"}, cmp_ins, i);
            branch = br;
         end
         if (pc_we) begin
            ins_valid = 1'b0;
            done = 1;
            e = sb.pop_front();
            check_val({tag, "_latency"}, n, e.lat);
            check_val({tag, "_pc_next"}, pc_next, e.npc);
            check_val({tag, "_flush"}, flush, e.fl);
            check_val({tag, "_link_we"}, link_we, e.lw);
            check_val({tag, "_link_data"}, link_data, e.ld);
            if (e.lw) check_val({tag, "_link_addr"}, link_addr, e.la);
            model_pc = e.npc;
         end
      end
      ins_valid = 1'b0;
      branch = 1'b0;
      if (!done) begin
         check_val({tag, "_timeout"}, 0, 1);
         sb.delete();
      end
      check_val({tag, "_cmp_cnt"}, cmp_cnt, model_isbr(i) ? 1 : 0);
      @(negedge clk);
      check_val({tag, "_pc"}, pc, model_pc);
      check_val({tag, "_pc_we_off"}, pc_we, 0);
      check_val({tag, "_compare_off"}, compare, 0);
      check_val({tag, "_idle"}, ins_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      issue("add", 32'h0109_5020, 32'd0, 1'b0, 1'b0);
      do_reset();
      issue("beq_t", 32'h1000_0004, 32'd0, 1'b1, 1'b0);
      check_val("beq_t_pc3014", pc, 32'h0000_3014);
      do_reset();
      issue("bne_nt", 32'h1400_FFFF, 32'd0, 1'b0, 1'b0);
      do_reset();
      issue("bne_t", 32'h1400_FFFF, 32'd0, 1'b1, 1'b0);
      check_val("bne_t_pc3000", pc, 32'h0000_3000);
      do_reset();
      issue("jal", 32'h0C00_0C10, 32'd0, 1'b0, 1'b0);
      check_val("jal_pc3040", pc, 32'h0000_3040);
      issue("jr", 32'h0020_0008, 32'h0000_3100, 1'b0, 1'b0);
      issue("jalr", 32'h0020_2809, 32'h0000_3201, 1'b0, 1'b0);
      issue("bgtz_nt", 32'h1C20_0010, 32'd0, 1'b0, 1'b0);
      issue("blez_t", 32'h1820_FFF0, 32'd0, 1'b1, 1'b0);
      issue("bltz_t", 32'h0420_0003, 32'd0, 1'b1, 1'b0);
      issue("bgez_nt", 32'h0421_0003, 32'd0, 1'b0, 1'b0);
      issue("regimm_seq", 32'h0422_0010, 32'd0, 1'b1, 1'b0);
      issue("beq_self", 32'h1000_0000, 32'd0, 1'b1, 1'b0);
      issue("jr_top", 32'h0020_0008, 32'hFFFF_FFF8, 1'b0, 1'b0);
      issue("beq_wrap", 32'h1000_0004, 32'd0, 1'b1, 1'b0);
      check_val("wrap_pc", pc, 32'h0000_000C);
      issue("hold_beq", 32'h1000_0002, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      check_val("hold_no_accept_pc_we", pc_we, 0);
      check_val("hold_no_accept_cmp", compare, 0);
      check_val("hold_pc", pc, model_pc);

      // Reset while a BEQ is in CMP drops it.
      do_reset();
      @(negedge clk);
      ins = 32'h1000_0004; ins_valid = 1'b1;
      @(negedge clk);
      ins_valid = 1'b0;
      check_val("midrst_in_cmp", compare, 1);
      rst_n = 1'b0; branch = 1'b1;
      @(negedge clk);
      branch = 1'b0;
      check_val("midrst_pc_we", pc_we, 0);
      check_val("midrst_compare", compare, 0);
      check_val("midrst_pc", pc, 32'h0000_3000);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("midrst_pc_we2", pc_we, 0);
      check_val("midrst_ready", ins_ready, 1);
      check_val("midrst_pc2", pc, 32'h0000_3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
